// File: rtl/instr_fetch_decode.sv
`timescale 1ns/1ps
// Multi-cycle fetch/decode stage sequencing the 8x8 regfile CTRL line (FETCH->DECODE->READ->WRITE).
// Optional feature macro BRANCH_EN: opcode 0x06 becomes a PC-relative jump resolved in DECODE.
module instr_fetch_decode #(
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [31:0]       i_imem_data,
  input  logic              i_stall,
  output logic [ADDR_W-1:0] o_pc,
  output logic [2:0]        o_inaddr,
  output logic [2:0]        o_out1addr,
  output logic [2:0]        o_out2addr,
  output logic [7:0]        o_imm,
  output logic              o_imm_sel,
  output logic              o_sub_sel,
  output logic [2:0]        o_alu_op,
  output logic              o_reg_ctrl,
  output logic              o_issue_valid,
  output logic              o_illegal
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_READ   = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_req;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [2:0]        r_inaddr;
  logic [2:0]        r_out1addr;
  logic [2:0]        r_out2addr;
  logic [7:0]        r_imm;
  logic              r_imm_sel;
  logic              r_sub_sel;
  logic [2:0]        r_alu_op;

  logic              w_ack;
  logic              w_legal;
  logic              w_branch;
  logic              w_imm_sel;
  logic              w_sub_sel;
  logic [2:0]        w_alu_op;
  logic              w_unused;

  // r_req is only ever set while in FETCH, so an ACK outside a request is dropped here.
  assign w_ack    = r_req & i_imem_ack;
  assign w_unused = ^{r_ir[23:19], r_ir[15:11]};

`ifdef BRANCH_EN
  logic signed [9:0]  w_br_off_s;
  logic [ADDR_W-1:0]  w_br_off;
  assign w_br_off_s = {r_ir[23:16], 2'b00};
  assign w_br_off   = ADDR_W'(w_br_off_s);
`endif

  always_comb begin
    w_legal   = 1'b0;
    w_branch  = 1'b0;
    w_imm_sel = 1'b0;
    w_sub_sel = 1'b0;
    w_alu_op  = 3'd0;
    case (r_ir[31:24])
      8'h00: begin w_legal = 1'b1; w_imm_sel = 1'b1; end
      8'h01: w_legal = 1'b1;
      8'h02: begin w_legal = 1'b1; w_alu_op = 3'd1; end
      8'h03: begin w_legal = 1'b1; w_sub_sel = 1'b1; w_alu_op = 3'd1; end
      8'h04: begin w_legal = 1'b1; w_alu_op = 3'd2; end
      8'h05: begin w_legal = 1'b1; w_alu_op = 3'd3; end
`ifdef BRANCH_EN
      8'h06: w_branch = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (w_ack) w_next = S_DECODE;
      S_DECODE: w_next = w_legal ? S_READ : S_FETCH;
      S_READ:   w_next = S_WRITE;
      S_WRITE:  if (!i_stall) w_next = S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_req      <= 1'b0;
      r_pc       <= ADDR_W'(RESET_PC);
      r_ir       <= '0;
      r_inaddr   <= '0;
      r_out1addr <= '0;
      r_out2addr <= '0;
      r_imm      <= '0;
      r_imm_sel  <= 1'b0;
      r_sub_sel  <= 1'b0;
      r_alu_op   <= '0;
    end else begin
      r_req <= (w_next == S_FETCH);
      if (w_ack) begin
        r_ir <= i_imem_data;
        r_pc <= r_pc + ADDR_W'(PC_STEP);
      end
`ifdef BRANCH_EN
      if (r_state == S_DECODE && w_branch) r_pc <= r_pc + w_br_off;
`endif
      // Decode fields only move on a legal DECODE exit and stay frozen through READ/WRITE.
      if (r_state == S_DECODE && w_legal) begin
        r_inaddr   <= r_ir[18:16];
        r_out1addr <= r_ir[10:8];
        r_out2addr <= r_ir[2:0];
        r_imm      <= r_ir[7:0];
        r_imm_sel  <= w_imm_sel;
        r_sub_sel  <= w_sub_sel;
        r_alu_op   <= w_alu_op;
      end
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_inaddr      = r_inaddr;
  assign o_out1addr    = r_out1addr;
  assign o_out2addr    = r_out2addr;
  assign o_imm         = r_imm;
  assign o_imm_sel     = r_imm_sel;
  assign o_sub_sel     = r_sub_sel;
  assign o_alu_op      = r_alu_op;
  assign o_reg_ctrl    = (r_state != S_WRITE);
  assign o_issue_valid = (r_state == S_WRITE);
  assign o_illegal     = (r_state == S_DECODE) & ~w_legal & ~w_branch;

endmodule
